// File: rtl/console_uart_tx_if.sv
// Native memory-bus bundle between the core store path and the console peripheral.
// Latency: none, wires only.
// Backpressure: the slave holds mem_ready low to stall. The master holds mem_valid until it sees mem_ready.
// Signals: mem_valid/mem_addr/mem_wdata/mem_wstrb (master->slave), mem_ready/mem_rdata (slave->master)
interface console_uart_tx_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/console_uart_tx.sv
// Console output peripheral: firmware bytes are buffered in a FIFO and serialised as 8N1 UART frames.
// Latency: mem_ready arrives 1 cycle after a hit. The start bit begins 1 cycle after the push when idle.
// Backpressure: a DATA push while the FIFO is full is stalled (mem_ready held low) until an entry drains.
// Ports: clk, resetn (sync, active-low), bus (slave modport: mem_valid/addr/wdata/wstrb -> mem_ready/rdata),
//        uart_tx (idle high), tx_busy (shifter active or FIFO non-empty)
module console_uart_tx #(
    parameter logic [31:0] ADDR_BASE    = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    console_uart_tx_if.slave      bus,
    output logic                  uart_tx,
    output logic                  tx_busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- bus decode / handshake ----------------
    logic          hit, is_status, is_write, push_req, accept, push, pop;
    logic          ack_q, full, empty;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   status_word;
    state_t        state_q, state_d;

    assign hit       = bus.mem_valid && (bus.mem_addr[31:3] == ADDR_BASE[31:3]);
    assign is_status = bus.mem_addr[2];
    assign is_write  = |bus.mem_wstrb;
    assign push_req  = hit && !is_status && bus.mem_wstrb[0];
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    // A full FIFO stalls only real pushes; everything else is acknowledged at once.
    assign accept    = hit && !ack_q && !(push_req && full);
    assign push      = accept && push_req;

    assign status_word = {16'h0000, 8'(count_q), 5'b00000, (state_q != S_IDLE), empty, full};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 32'h0;
            ack_q         <= 1'b0;
        end else begin
            bus.mem_ready <= accept;
            bus.mem_rdata <= (accept && !is_write && is_status) ? status_word : 32'h0;
            // Remember the accepted request until the master drops mem_valid, so it is acked exactly once.
            if (accept)
                ack_q <= 1'b1;
            else if (!bus.mem_valid)
                ack_q <= 1'b0;
        end
    end

    // ---------------- byte FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]    head;

    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= bus.mem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // ---------------- TX serialiser ----------------
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift right so the next bit to send always sits at [1] before the shift.
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit so queued bytes leave without idle gaps.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            tx_busy <= (state_d != S_IDLE) || (count_d != '0);
        end
    end

    assign uart_tx = tx_q;

    // Only byte lane 0 carries data and the window is word addressed.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.mem_addr[1:0], bus.mem_wdata[31:8]};
endmodule

// File: tb/tb_console_uart_tx.sv
module tb_console_uart_tx;
    localparam int          C       = 4;
    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam logic [28:0] BASE_HI = 29'h0200_0000;
    localparam int          FRAME   = 10 * C;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic uart_tx, tx_busy;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    console_uart_tx_if bus();

    console_uart_tx #(
        .ADDR_BASE   (BASE),
        .FIFO_DEPTH  (16),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy)
    );

    // Scoreboard queues: expected bus responses and expected serial bytes.
    logic [31:0] exp_rd_q [$];
    logic [7:0]  exp_byte_q [$];
    int          frame_start_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus transfer. A hit queues its expected rdata; a DATA push queues its byte for the line monitor.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            input logic expect_hit, input logic [31:0] exp_rdata, input int max_wait,
                            output int waited, output logic acked);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        if (expect_hit) exp_rd_q.push_back(exp_rdata);
        waited = 0;
        acked  = 1'b0;
        while (!acked && waited < max_wait) begin
            @(negedge clk);
            waited++;
            if (bus.mem_ready === 1'b1) acked = 1'b1;
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        if (expect_hit && !acked) begin
            tests++;
            fails++;
            $display("FAIL bus_timeout: addr 0x%08h not acked within %0d cycles", addr, max_wait);
            void'(exp_rd_q.pop_back());
        end
        if (expect_hit && acked && wstrb[0] && !addr[2]) exp_byte_q.push_back(wdata[7:0]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((tx_busy !== 1'b0 || exp_byte_q.size() != 0) && n < budget);
        check("drain_within_budget", (n < budget), 1);
        check("idle_line_high", uart_tx, 1);
    endtask

    // Bus monitor: every mem_ready must match the oldest outstanding expected response.
    logic [31:0] bus_e;
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (bus.mem_ready === 1'b1) begin
                    if (exp_rd_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL bus_unexpected_ready: rdata 0x%08h with no request outstanding", bus.mem_rdata);
                    end else begin
                        bus_e = exp_rd_q.pop_front();
                        check("bus_rdata", bus.mem_rdata, bus_e);
                    end
                end else begin
                    check("rdata_zero_when_not_ready", bus.mem_rdata, 32'h0);
                end
            end
        end
    end

    // Line monitor: decodes 8N1 frames at C samples per bit and compares against expected bytes.
    logic       mon_act = 1'b0;
    logic       mon_unexp, mon_ok, exp_line;
    int         mon_s, mon_idx;
    logic [7:0] mon_b, mon_got;
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mon_act = 1'b0;
                exp_byte_q.delete();
            end else if (!mon_act) begin
                if (uart_tx === 1'b0) begin
                    mon_act   = 1'b1;
                    mon_s     = 1;
                    mon_ok    = 1'b1;
                    mon_got   = 8'h00;
                    mon_unexp = (exp_byte_q.size() == 0);
                    mon_b     = mon_unexp ? 8'h00 : exp_byte_q[0];
                    frame_start_q.push_back(cyc);
                    if (mon_unexp) begin
                        tests++;
                        fails++;
                        $display("FAIL uart_unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                    end
                end
            end else begin
                mon_idx = mon_s / C;
                if (mon_idx == 9)      exp_line = 1'b1;
                else if (mon_idx == 0) exp_line = 1'b0;
                else                   exp_line = mon_b[mon_idx-1];
                if (uart_tx !== exp_line) mon_ok = 1'b0;
                if (mon_idx >= 1 && mon_idx <= 8 && (mon_s % C) == C / 2) mon_got[mon_idx-1] = uart_tx;
                mon_s++;
                if (mon_s == FRAME) begin
                    mon_act = 1'b0;
                    if (!mon_unexp) begin
                        tests++;
                        if (!mon_ok) begin
                            fails++;
                            $display("FAIL uart_frame: got byte 0x%02h (or bad timing) expected 0x%02h", mon_got, mon_b);
                        end
                        void'(exp_byte_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          w, lat, n, gap;
        logic        a;
        logic [7:0]  b;
        logic [31:0] ma;
        int          waits [18];

        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        resetn        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mem_ready", bus.mem_ready, 0);
        check("reset_mem_rdata", bus.mem_rdata, 32'h0);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_tx_busy", tx_busy, 0);
        resetn = 1'b1;

        // STATUS after reset: empty only.
        bus_xfer(BASE + 4, 32'h0, 4'h0, 1'b1, 32'h0000_0002, 50, w, a);
        check("status_ack_latency", w, 1);
        check("line_idle_after_reset", uart_tx, 1);

        // Single byte 0x55.
        frame_start_q.delete();
        bus_xfer(BASE, 32'h55, 4'b0001, 1'b1, 32'h0, 50, w, a);
        check("write_ack_latency", w, 1);
        check("busy_after_push", tx_busy, 1);
        lat = 0;
        while (uart_tx === 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("start_bit_within_2", (lat >= 1 && lat <= 2), 1);
        wait_idle(200);
        check("one_frame_for_0x55", frame_start_q.size(), 1);

        // 18 back-to-back bytes: 17 fit (shifter + 16 queued), the 18th waits for the first frame.
        frame_start_q.delete();
        for (int i = 0; i < 18; i++) begin
            bus_xfer(BASE, 32'h41 + i, 4'b0001, 1'b1, 32'h0, 200, w, a);
            waits[i] = w;
        end
        for (int i = 0; i < 17; i++) check($sformatf("b2b_no_stall_%0d", i + 1), waits[i], 1);
        check("b2b_18th_stalls", (waits[17] > 1 && waits[17] <= 12), 1);
        wait_idle(18 * FRAME + 100);
        check("b2b_frame_count", frame_start_q.size(), 18);
        if (frame_start_q.size() == 18)
            check("b2b_no_gaps", frame_start_q[17] - frame_start_q[0], 17 * FRAME);

        // Non-pushing accesses leave the FIFO count alone.
        bus_xfer(BASE, 32'h11, 4'b0001, 1'b1, 32'h0, 50, w, a);
        bus_xfer(BASE, 32'h22, 4'b0001, 1'b1, 32'h0, 50, w, a);
        bus_xfer(BASE, 32'h33, 4'b0001, 1'b1, 32'h0, 50, w, a);
        bus_xfer(BASE, 32'h0, 4'h0, 1'b1, 32'h0, 50, w, a);
        check("data_read_acked_once", w, 1);
        bus_xfer(BASE, 32'hEE, 4'b0010, 1'b1, 32'h0, 50, w, a);
        check("lane1_write_acked", a, 1);
        bus_xfer(BASE + 4, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 50, w, a);
        check("status_write_acked", a, 1);
        bus_xfer(BASE + 4, 32'h0, 4'h0, 1'b1, 32'h0000_0204, 50, w, a);
        wait_idle(4 * FRAME);

        // Address misses.
        bus_xfer(32'h2000_0000, 32'h77, 4'b0001, 1'b0, 32'h0, 8, w, a);
        check("miss_2000_no_ack", a, 0);
        bus_xfer(BASE + 8, 32'h78, 4'b0001, 1'b0, 32'h0, 8, w, a);
        check("miss_base8_no_ack", a, 0);
        bus_xfer(BASE + 8, 32'h0, 4'h0, 1'b0, 32'h0, 8, w, a);
        check("miss_read_no_ack", a, 0);
        repeat (4) @(negedge clk);
        check("miss_no_push", tx_busy, 0);

        // Randomised bursts with gaps and interleaved misses.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                bus_xfer(BASE | 32'($urandom_range(0, 3)), {24'($urandom), b}, 4'b0001 | 4'($urandom), 1'b1, 32'h0, 100, w, a);
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                if ($urandom_range(0, 2) == 0) begin
                    ma = $urandom;
                    if (ma[31:3] == BASE_HI) ma[31] = ~ma[31];
                    bus_xfer(ma, $urandom, 4'($urandom), 1'b0, 32'h0, 6, w, a);
                    check("random_miss_no_ack", a, 0);
                end
            end
            wait_idle(6 * FRAME + 100);
        end

        // Reset in the middle of data bit 3 with five more bytes queued.
        frame_start_q.delete();
        bus_xfer(BASE, 32'hA5, 4'b0001, 1'b1, 32'h0, 50, w, a);
        for (int k = 0; k < 5; k++) bus_xfer(BASE, $urandom, 4'b0001, 1'b1, 32'h0, 50, w, a);
        n = 0;
        while (frame_start_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_case_frame_started", (frame_start_q.size() != 0), 1);
        if (frame_start_q.size() != 0) begin
            while (cyc < frame_start_q[0] + 4 * C + 1) @(negedge clk);
            check("line_low_in_bit3", uart_tx, 0);
            resetn = 1'b0;
            @(negedge clk);
            check("reset_midframe_line_high", uart_tx, 1);
            check("reset_midframe_busy_low", tx_busy, 0);
            @(negedge clk);
            resetn = 1'b1;
            repeat (2 * FRAME) @(negedge clk);
            check("no_frames_after_flush", tx_busy, 0);
            bus_xfer(BASE + 4, 32'h0, 4'h0, 1'b1, 32'h0000_0002, 50, w, a);
        end

        repeat (4) @(negedge clk);
        check("all_responses_seen", exp_rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
